// File: rtl/demux_pkg.sv
// Shared constants and lane-counter state type for the TDM 1:4 demultiplexer.
package demux_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] LANE0 = 2'b00;
    localparam logic [SEL_W-1:0] LANE1 = 2'b01;
    localparam logic [SEL_W-1:0] LANE2 = 2'b10;
    localparam logic [SEL_W-1:0] LANE3 = 2'b11;

    localparam logic [LANES-1:0] FRAME_FULL = 4'b1111;

    typedef enum logic [SEL_W-1:0] {
        L0 = 2'b00,
        L1 = 2'b01,
        L2 = 2'b10,
        L3 = 2'b11
    } lane_state_e;

    // One-hot lane mask for a lane index.
    function automatic logic [LANES-1:0] lane_onehot(input logic [SEL_W-1:0] idx);
        return LANES'(1) << idx;
    endfunction

endpackage

// File: rtl/tdm_demux_1to4_if.sv
// Input-stream and frame-output bundle of the TDM 1:4 demultiplexer.
// sel_load/sel_in exist only when SEL_OVERRIDE_EN is defined.
interface tdm_demux_1to4_if #(
    parameter int unsigned WIDTH = 4
);
    import demux_pkg::*;

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_sync;
    logic             din_ready;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] y3;
    logic [LANES-1:0] lane_vld;
    logic [SEL_W-1:0] sel;
    logic             frame_valid;
    logic             frame_ready;
    logic             frame_err;
`ifdef SEL_OVERRIDE_EN
    logic             sel_load;
    logic [SEL_W-1:0] sel_in;
`endif

    modport master (
        output din, din_valid, din_sync, frame_ready,
`ifdef SEL_OVERRIDE_EN
        output sel_load, sel_in,
`endif
        input  din_ready, y0, y1, y2, y3, lane_vld, sel, frame_valid, frame_err
    );

    modport slave (
        input  din, din_valid, din_sync, frame_ready,
`ifdef SEL_OVERRIDE_EN
        input  sel_load, sel_in,
`endif
        output din_ready, y0, y1, y2, y3, lane_vld, sel, frame_valid, frame_err
    );

endinterface

// File: rtl/tdm_demux_ctrl.sv
// Lane counter, lane-valid tracking, frame handshake and sync-error detection.
// SEL_OVERRIDE_EN adds an explicit lane load that outranks din_sync.
module tdm_demux_ctrl
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_din_valid,
    input  logic             i_din_sync,
    input  logic             i_frame_ready,
`ifdef SEL_OVERRIDE_EN
    input  logic             i_sel_load,
    input  logic [SEL_W-1:0] i_sel_in,
`endif
    output logic             o_din_ready_c,
    output logic [LANES-1:0] o_lane_we_c,
    output logic [LANES-1:0] o_lane_vld,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_frame_valid,
    output logic             o_frame_err
);

    lane_state_e      r_state;
    lane_state_e      w_state_nxt;
    logic [LANES-1:0] r_lane_vld;
    logic [LANES-1:0] w_lane_vld_nxt;
    logic             r_frame_valid;
    logic             w_frame_valid_nxt;
    logic             r_frame_err;
    logic             w_frame_err_nxt;
    logic             w_accept;
    logic             w_xfer;
    logic [SEL_W-1:0] w_base;
    logic [SEL_W-1:0] w_idx;

    // A frame leaving this edge frees the block to take a word on the same edge.
    assign o_din_ready_c = !r_frame_valid || i_frame_ready;
    assign w_accept      = i_din_valid && o_din_ready_c;
    assign w_xfer        = r_frame_valid && i_frame_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= L0;
            r_lane_vld    <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lane_vld    <= w_lane_vld_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_frame_err   <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_base            = w_xfer ? LANE0 : r_state;
        w_idx             = w_base;
        w_state_nxt       = lane_state_e'(w_base);
        w_lane_vld_nxt    = w_xfer ? '0 : r_lane_vld;
        w_frame_valid_nxt = r_frame_valid && !w_xfer;
        w_frame_err_nxt   = 1'b0;
        o_lane_we_c       = '0;

        if (w_accept) begin
`ifdef SEL_OVERRIDE_EN
            if (i_sel_load) begin
                w_idx = i_sel_in;
            end else
`endif
            if (i_din_sync && (w_base != LANE0)) begin
                // Sync mid-frame: drop the partial frame and restart at lane 0.
                w_idx           = LANE0;
                w_lane_vld_nxt  = '0;
                w_frame_err_nxt = 1'b1;
            end
            o_lane_we_c    = lane_onehot(w_idx);
            w_lane_vld_nxt = w_lane_vld_nxt | lane_onehot(w_idx);
            w_state_nxt    = lane_state_e'(w_idx + SEL_W'(1));
            if (w_lane_vld_nxt == FRAME_FULL) begin
                w_frame_valid_nxt = 1'b1;
            end
        end
    end

    assign o_lane_vld    = r_lane_vld;
    assign o_sel         = r_state;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_err   = r_frame_err;

endmodule

// File: rtl/tdm_demux_1to4.sv
// TDM 1:4 demultiplexer top: four registered lanes written by the control block.
// SEL_OVERRIDE_EN enables the sel_load/sel_in lane override.
module tdm_demux_1to4
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    tdm_demux_1to4_if.slave   bus
);

    logic [WIDTH-1:0] r_y [LANES];
    logic [LANES-1:0] w_lane_we;
    logic             w_din_ready;
    logic [LANES-1:0] w_lane_vld;
    logic [SEL_W-1:0] w_sel;
    logic             w_frame_valid;
    logic             w_frame_err;

    tdm_demux_ctrl u_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_din_valid   (bus.din_valid),
        .i_din_sync    (bus.din_sync),
        .i_frame_ready (bus.frame_ready),
`ifdef SEL_OVERRIDE_EN
        .i_sel_load    (bus.sel_load),
        .i_sel_in      (bus.sel_in),
`endif
        .o_din_ready_c (w_din_ready),
        .o_lane_we_c   (w_lane_we),
        .o_lane_vld    (w_lane_vld),
        .o_sel         (w_sel),
        .o_frame_valid (w_frame_valid),
        .o_frame_err   (w_frame_err)
    );

    // Lane data is only cleared by reset; stale words stay until overwritten.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LANES); i++) begin
                r_y[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (w_lane_we[i]) begin
                    r_y[i] <= bus.din;
                end
            end
        end
    end

    assign bus.y0          = r_y[0];
    assign bus.y1          = r_y[1];
    assign bus.y2          = r_y[2];
    assign bus.y3          = r_y[3];
    assign bus.din_ready   = w_din_ready;
    assign bus.lane_vld    = w_lane_vld;
    assign bus.sel         = w_sel;
    assign bus.frame_valid = w_frame_valid;
    assign bus.frame_err   = w_frame_err;

endmodule
